// File: rtl/sdhc_ftl_dma.sv
// Moves one 512-byte SD block per command between the SDHC word streams and the
// FTL wishbone slave using classic single cycles, with cyc held for the whole block.
module sdhc_ftl_dma #(
   parameter int BLOCK_WORDS = 128,
   parameter int TIMEOUT     = 65535
) (
   input  logic        clk_50,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [22:0] cmd_block,
   input  logic [31:0] wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        busy,
   output logic        done,
   output logic        err_timeout,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   input  logic        wbm_ack_i,
   output logic [2:0]  wbm_cti_o,
   output logic [1:0]  wbm_bte_o
);
   localparam int IW = $clog2(BLOCK_WORDS);

   typedef enum logic [2:0] {IDLE, WR_WAIT, WR_BUS, RD_BUS, RD_HOLD, FIN} state_t;

   state_t        state_q, state_d;
   logic [22:0]   blk_q, blk_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          we_q, we_d;
   logic          cyc_q, cyc_d;
   logic          stb_q, stb_d;
   logic          err_q, err_d;
   logic          rv_q, rv_d;
   logic [31:0]   wdat_q, wdat_d;
   logic [31:0]   rdat_q, rdat_d;
   logic [15:0]   tmo_q, tmo_d;
   logic          last_word;
   logic          tmo_hit;

   assign last_word = (idx_q == IW'(BLOCK_WORDS - 1));
   // An ack in the same cycle as the limit wins, so the abort requires !ack.
   assign tmo_hit   = stb_q && !wbm_ack_i && (tmo_q == 16'(TIMEOUT - 1));

   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_q <= IDLE;
         blk_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
         rv_q    <= 1'b0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         err_q   <= err_d;
         rv_q    <= rv_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      idx_d   = idx_q;
      we_d    = we_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      err_d   = err_q;
      rv_d    = rv_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      tmo_d   = (stb_q && !wbm_ack_i) ? tmo_q + 16'd1 : 16'd0;
      case (state_q)
         IDLE: begin
            err_d = 1'b0;
            if (cmd_valid) begin
               blk_d = cmd_block;
               we_d  = cmd_write;
               idx_d = '0;
               cyc_d = 1'b1;
               if (cmd_write) begin
                  state_d = WR_WAIT;
               end else begin
                  stb_d   = 1'b1;
                  state_d = RD_BUS;
               end
            end
         end
         WR_WAIT: begin
            if (wr_valid) begin
               wdat_d  = wr_data;
               stb_d   = 1'b1;
               we_d    = 1'b1;
               state_d = WR_BUS;
            end
         end
         WR_BUS: begin
            if (wbm_ack_i) begin
               stb_d = 1'b0;
               if (last_word) begin
                  cyc_d   = 1'b0;
                  state_d = FIN;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = WR_WAIT;
               end
            end else if (tmo_hit) begin
               stb_d   = 1'b0;
               cyc_d   = 1'b0;
               err_d   = 1'b1;
               state_d = FIN;
            end
         end
         RD_BUS: begin
            if (wbm_ack_i) begin
               rdat_d  = wbm_dat_i;
               rv_d    = 1'b1;
               stb_d   = 1'b0;
               state_d = RD_HOLD;
            end else if (tmo_hit) begin
               stb_d   = 1'b0;
               cyc_d   = 1'b0;
               err_d   = 1'b1;
               state_d = FIN;
            end
         end
         RD_HOLD: begin
            if (rd_ready) begin
               rv_d = 1'b0;
               if (last_word) begin
                  cyc_d   = 1'b0;
                  state_d = FIN;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  stb_d   = 1'b1;
                  state_d = RD_BUS;
               end
            end
         end
         FIN: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FIN);
   assign err_timeout = (state_q == FIN) && err_q;
   assign wr_ready    = (state_q == WR_WAIT);
   assign rd_valid    = rv_q;
   assign rd_data     = rdat_q;
   assign wbm_adr_o   = {blk_q, idx_q, 2'b00};
   assign wbm_dat_o   = wdat_q;
   assign wbm_sel_o   = 4'hF;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = stb_q;
   assign wbm_we_o    = we_q & cyc_q;
   assign wbm_cti_o   = 3'b000;
   assign wbm_bte_o   = 2'b00;
endmodule

// File: tb/tb_sdhc_ftl_dma.sv
// Scoreboard bench for sdhc_ftl_dma: stimulus pushes expected bus/stream/done events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sdhc_ftl_dma;
   logic        clk_50 = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_write;
   logic [22:0] cmd_block;
   logic        cmd_ready;
   logic [31:0] wr_data;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid, rd_ready;
   logic        busy, done, err_timeout;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic [3:0]  wbm_sel_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic [2:0]  wbm_cti_o;
   logic [1:0]  wbm_bte_o;

   sdhc_ftl_dma #(.BLOCK_WORDS(128), .TIMEOUT(16)) dut (
      .clk_50(clk_50), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_block(cmd_block),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy), .done(done), .err_timeout(err_timeout),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_sel_o(wbm_sel_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_ack_i(wbm_ack_i),
      .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o)
   );

   always #5 clk_50 = ~clk_50;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } bus_t;

   bus_t        exp_bus[$];
   logic [31:0] exp_rd[$];
   bit          exp_done[$];

   int          checks = 0;
   int          errors = 0;
   int          slave_wait = 0;
   bit          mute_en = 1'b0;
   logic [6:0]  mute_idx = 7'd0;
   logic [31:0] salt = 32'h0;
   bit          in_cmd = 1'b0;
   bit          chk_ready = 1'b0;
   int          run = 0;
   int          last_run = 0;
   logic [31:0] prev_dat = 32'h0;
   bus_t        mon_e;
   bit          mon_d;
   logic [31:0] mon_r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Wishbone slave: acks after slave_wait wait states, never acks the muted word.
   int scnt = 0;
   initial begin
      wbm_ack_i = 1'b0;
      wbm_dat_i = 32'h0;
      forever begin
         @(posedge clk_50);
         #1;
         if (!wbm_stb_o) begin
            scnt      = 0;
            wbm_ack_i = 1'b0;
         end else begin
            wbm_ack_i = (scnt == slave_wait) && !(mute_en && (wbm_adr_o[8:2] == mute_idx));
            if (wbm_ack_i) scnt = 0;
            else scnt++;
         end
         wbm_dat_i = ~wbm_adr_o ^ salt;
      end
   end

   // Monitor / scoreboard
   always @(negedge clk_50) begin
      if (!reset) begin
         if (wbm_stb_o) begin
            run++;
            if (run > 1) chk("dat_stable", wbm_dat_o, prev_dat);
         end else begin
            if (run != 0) last_run = run;
            run = 0;
         end
         prev_dat = wbm_dat_o;
         if (wbm_stb_o && wbm_ack_i) begin
            if (exp_bus.size() == 0) begin
               checks++; errors++;
               $display("FAIL bus_unexpected: adr %h, none expected", wbm_adr_o);
            end else begin
               mon_e = exp_bus.pop_front();
               chk("bus_adr", wbm_adr_o, mon_e.adr);
               chk("bus_we", 32'(wbm_we_o), 32'(mon_e.we));
               if (mon_e.we) chk("bus_dat", wbm_dat_o, mon_e.dat);
               chk("stb_len", 32'(run), 32'(slave_wait + 1));
            end
         end
         if (rd_valid && rd_ready) begin
            if (exp_rd.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_unexpected: data %h, none expected", rd_data);
            end else begin
               mon_r = exp_rd.pop_front();
               chk("rd_data", rd_data, mon_r);
            end
         end
         chk("wr_ready_excl", 32'(wr_ready && (wbm_stb_o || !wbm_cyc_o || !wbm_we_o)), 32'd0);
         chk("rd_valid_excl", 32'(rd_valid && (wbm_stb_o || wbm_we_o || !wbm_cyc_o)), 32'd0);
         if (chk_ready) begin
            chk("ready_after_done", 32'(cmd_ready), 32'd1);
            chk_ready = 1'b0;
         end
         if (in_cmd && !done) chk("cyc_held", 32'(wbm_cyc_o), 32'd1);
         if (done) begin
            if (exp_done.size() == 0) begin
               checks++; errors++;
               $display("FAIL done_unexpected: done=1 with none expected at %0t", $time);
            end else begin
               mon_d = exp_done.pop_front();
               chk("err_timeout", 32'(err_timeout), 32'(mon_d));
               chk("done_cyc", 32'(wbm_cyc_o), 32'd0);
               chk("done_stb", 32'(wbm_stb_o), 32'd0);
               if (mon_d) chk("tmo_len", 32'(last_run), 32'd16);
            end
            chk_ready = 1'b1;
         end else begin
            chk("err_alone", 32'(err_timeout), 32'd0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_50);
         #1;
      end
   endtask

   task automatic run_cmd(input bit wr, input logic [22:0] blk, input int wait_c, input int vmode,
                          input int rmode, input int mute_w, input int rst_word, input int stray_at,
                          output int ncyc);
      logic [31:0] words [128];
      logic [31:0] a;
      bus_t        e;
      int          n, wi, rdn;
      bit          hs_wr, hs_rd, got_done;
      slave_wait = wait_c;
      mute_en    = (mute_w >= 0);
      mute_idx   = (mute_w >= 0) ? 7'(mute_w) : 7'd0;
      n          = (mute_w >= 0) ? mute_w : 128;
      for (int i = 0; i < 128; i++) begin
         words[i] = (vmode == 0) ? 32'h1000 + 32'(i) : $urandom;
         a = 32'(blk) * 32'd512 + 32'(i) * 32'd4;
         if (i < n) begin
            e.we = wr; e.adr = a; e.dat = words[i];
            exp_bus.push_back(e);
            if (!wr) exp_rd.push_back(~a ^ salt);
         end
      end
      if (rst_word < 0) exp_done.push_back(mute_w >= 0);
      cmd_valid = 1'b1; cmd_write = wr; cmd_block = blk;
      @(posedge clk_50);
      #1;
      cmd_valid = 1'b0; in_cmd = 1'b1;
      ncyc = 1; wi = 0; rdn = 0;
      forever begin
         wr_valid = wr && (wi < 128) && (vmode == 0 || $urandom_range(0, 1) == 1);
         wr_data  = (wi < 128) ? words[wi] : 32'h0;
         rd_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((ncyc / 3) % 2 == 0) : ($urandom_range(0, 1) == 1);
         if (ncyc == stray_at) begin
            cmd_valid = 1'b1; cmd_block = 23'd9; cmd_write = !wr;
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk_50);
         hs_wr = wr_valid && wr_ready;
         hs_rd = rd_valid && rd_ready;
         got_done = done;
         @(posedge clk_50);
         #1;
         ncyc++;
         if (hs_wr) wi++;
         if (hs_rd) rdn++;
         if (got_done) break;
         if (rst_word >= 0 && rdn == rst_word) begin
            in_cmd = 1'b0; reset = 1'b1; rd_ready = 1'b0; wr_valid = 1'b0;
            @(posedge clk_50);
            #1;
            chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
            chk("rst_stb", 32'(wbm_stb_o), 32'd0);
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            exp_bus.delete();
            exp_rd.delete();
            reset = 1'b0;
            break;
         end
         if (ncyc > 6000) begin
            checks++; errors++;
            $display("FAIL cmd_bound: no done after %0d cycles", ncyc);
            break;
         end
      end
      in_cmd = 1'b0; cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
   endtask

   task automatic drain_check();
      idle(4);
      chk("q_bus_empty", 32'(exp_bus.size()), 32'd0);
      chk("q_rd_empty", 32'(exp_rd.size()), 32'd0);
      chk("q_done_empty", 32'(exp_done.size()), 32'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int ncyc;
   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_block = '0;
      wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
      repeat (3) @(posedge clk_50);
      #1;
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset_sel", 32'(wbm_sel_o), 32'hF);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_cyc_stb_we", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
      chk("reset_adr", wbm_adr_o, 32'd0);
      chk("reset_dat", wbm_dat_o, 32'd0);
      chk("reset_rd", {rd_data[30:0], rd_valid}, 32'd0);
      chk("reset_pulses", {29'd0, done, err_timeout, wr_ready}, 32'd0);
      chk("reset_cti_bte", {27'd0, wbm_cti_o, wbm_bte_o}, 32'd0);
      reset = 1'b0;
      idle(2);

      // Zero-wait write of block 5, stream held valid
      salt = 32'h0;
      run_cmd(1'b1, 23'd5, 0, 0, 0, -1, -1, -1, ncyc);
      chk("t1_cycles_in_range", 32'(ncyc >= 256 && ncyc <= 260), 32'd1);
      drain_check();

      // Read of the top block, rd_ready toggling every 3 cycles
      run_cmd(1'b0, 23'h7FFFFF, 0, 0, 1, -1, -1, -1, ncyc);
      drain_check();

      // Write with 7 wait states per word
      run_cmd(1'b1, 23'h1234, 7, 1, 0, -1, -1, -1, ncyc);
      drain_check();

      // Write timeout on word 3, then a normal read, then a read timeout
      run_cmd(1'b1, 23'h42, 0, 1, 0, 3, -1, -1, ncyc);
      drain_check();
      salt = $urandom;
      run_cmd(1'b0, 23'h43, 2, 0, 2, -1, -1, -1, ncyc);
      drain_check();
      run_cmd(1'b0, 23'd77, 1, 0, 2, 100, -1, -1, ncyc);
      drain_check();

      // Reset during word 40 of a read; no done may follow
      run_cmd(1'b0, 23'h100, 1, 0, 2, -1, 40, -1, ncyc);
      idle(20);
      chk("post_reset_idle", 32'(cmd_ready), 32'd1);
      drain_check();

      // Stray command while busy is ignored
      run_cmd(1'b1, 23'h200, 1, 1, 0, -1, -1, 50, ncyc);
      drain_check();

      // Randomized commands
      for (int k = 0; k < 4; k++) begin
         salt = $urandom;
         run_cmd(1'($urandom_range(0, 1)), 23'($urandom), $urandom_range(0, 3), 1, 2, -1, -1, -1, ncyc);
         drain_check();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sdhc_ftl_dma.md
Name: sdhc_ftl_dma

Overview:
Upstream stage of the FTL wishbone slave. It moves one 512-byte SD block per command between the SDHC data-path word streams and the FTL slave port, using wishbone classic single cycles. It generates word addresses from the SD block number and holds cyc for the whole block. It reports completion, and reports a bus timeout if the FTL never acks.

Parameters:
BLOCK_WORDS, 128, 32-bit words per block (512 bytes); must be a power of two.
TIMEOUT, 65535, clk_50 cycles stb may stay high without ack before abort; 16-bit counter.

Ports:
clk_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = stream to FTL (SD write), 0 = FTL to stream (SD read)
cmd_block  in  23  SD block number
wr_data  in  32  write-stream word
wr_valid  in  1  write-stream valid
wr_ready  out  1  write-stream ready
rd_data  out  32  read-stream word
rd_valid  out  1  read-stream valid
rd_ready  in  1  read-stream ready
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of command
err_timeout  out  1  one-cycle pulse, coincident with done, on abort
wbm_adr_o  out  32  {blk_q, word_idx, 2'b00}
wbm_dat_o  out  32  write data
wbm_dat_i  in  32  read data
wbm_sel_o  out  4  constant 4'hF
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_we_o  out  1  write enable (= latched cmd_write while cyc)
wbm_ack_i  in  1  acknowledge
wbm_cti_o  out  3  constant 3'b000
wbm_bte_o  out  2  constant 2'b00

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1 and wbm_sel_o=4'hF.
- Reset mid-transfer: cyc and stb drop at the same edge; no done pulse is issued.
- States: IDLE, WR_WAIT, WR_BUS, RD_BUS, RD_HOLD, FIN.
- IDLE:
  - On cmd_valid, latch cmd_block, cmd_write and word_idx=0, and assert cyc.
  - Next state is WR_WAIT if cmd_write=1, else RD_BUS with stb=1.
  - cmd_valid while busy is ignored; nothing is queued.
- WR_WAIT:
  - wr_ready=1.
  - On wr_valid, load wbm_dat_o, set stb=1 and we=1, and go to WR_BUS.
  - Accepted word at cycle N gives stb high at N+1.
- WR_BUS:
  - On ack, drop stb and increment word_idx.
  - If the acked word was the last (word_idx == BLOCK_WORDS-1), go to FIN; else go to WR_WAIT.
  - A zero-wait slave gives a minimum of 2 cycles per word.
- RD_BUS:
  - On ack, register wbm_dat_i into rd_data, set rd_valid=1, drop stb, and go to RD_HOLD.
- RD_HOLD:
  - rd_data and rd_valid are held until rd_ready.
  - On rd_valid && rd_ready: if that was the last word, go to FIN; else increment word_idx, set stb=1 and go to RD_BUS.
- FIN: cyc=0, done=1 for one cycle, then IDLE. cmd_ready returns on the following cycle.
- Address: wbm_adr_o[31:9]=blk_q, [8:2]=word_idx, [1:0]=0.
  - word_idx is log2(BLOCK_WORDS) bits and never wraps within a command.
- Timeout:
  - The counter clears whenever stb=0 and increments each cycle stb=1 && !ack.
  - When it reaches TIMEOUT, drop stb and cyc, pulse done and err_timeout together, and return to IDLE.
  - A partial block stays partial; rd_valid is never raised for the aborted word.
- Simultaneous events: an ack in the same cycle the counter reaches TIMEOUT counts as success; no error is raised.
- Stream handshakes: wr_ready is never high outside WR_WAIT, and rd_valid is never high outside RD_HOLD.

Test Plan:
1. Write cmd_block=5 with a zero-wait ack slave and wr_valid held high with data 0x1000+i -> 128 writes at addr 0x00000A00..0x00000BFC, data 0x1000..0x107F, we=1, cyc continuous; done 1 cycle after the last ack; total 258±2 cycles.
2. Read cmd_block=0x7FFFFF, slave returns ~addr, rd_ready toggling every 3 cycles -> addr 0xFFFFFE00..0xFFFFFFFC; stream yields 128 words equal to ~addr in order; no stb while rd_valid=1.
3. Write where the slave acks only after 7 wait cycles per word -> stb held 8 cycles per word with wbm_dat_o stable; wr_ready=0 throughout.
4. TIMEOUT=16, slave never acks on word 3 -> 16 cycles later stb=cyc=0, done=err_timeout=1 same cycle, cmd_ready=1 next cycle; next command runs normally.
5. Assert reset during word 40 of a read -> cyc, stb and rd_valid are 0 at the next edge, done is never pulsed, and cmd_ready=1.
6. Pulse cmd_valid with cmd_block=9 during an active command -> the request is ignored; all addresses keep the original block number and there is exactly one done.
